// File: rtl/ctrl_pkg.sv
// Shared state encodings for the control exit/benchmark monitor.
package ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } top_state_e;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_RUN  = 1'b1
  } bench_state_e;

endpackage

// File: rtl/ctrl_bench_timer.sv
// Times benchmark regions by ID and hands (id, length) pairs to a sink
// through a one-entry valid/ready buffer with a sticky overflow flag.
module ctrl_bench_timer
  import ctrl_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DataWidth-1:0] benchmark,
  input  logic                 ready,
  output logic                 active,
  output logic                 valid,
  output logic [DataWidth-1:0] id,
  output logic [CntWidth-1:0]  cycles,
  output logic                 ovf
);

  localparam logic [CntWidth-1:0] LenMax = '1;
  localparam logic [CntWidth-1:0] LenOne = CntWidth'(1);

  bench_state_e         state_q, state_d;
  logic [DataWidth-1:0] cur_id_q, cur_id_d;
  logic [CntWidth-1:0]  len_q, len_d;
  logic                 emit;

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] buf_id_q, buf_id_d;
  logic [CntWidth-1:0]  buf_len_q, buf_len_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= B_IDLE;
      cur_id_q  <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      buf_id_q  <= '0;
      buf_len_q <= '0;
      ovf_q     <= 1'b0;
    end else if (clear) begin
      state_q   <= B_IDLE;
      cur_id_q  <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      buf_id_q  <= '0;
      buf_len_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      buf_id_q  <= buf_id_d;
      buf_len_q <= buf_len_d;
      ovf_q     <= ovf_d;
    end
  end

  // A region ends either on a return to zero or on a switch to another ID.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    len_d    = len_q;
    emit     = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (benchmark != '0) begin
          cur_id_d = benchmark;
          len_d    = LenOne;
          state_d  = B_RUN;
        end
      end
      B_RUN: begin
        if (benchmark == cur_id_q) begin
          if (len_q != LenMax) begin
            len_d = len_q + LenOne;
          end
        end else if (benchmark == '0) begin
          emit    = 1'b1;
          state_d = B_IDLE;
        end else begin
          emit     = 1'b1;
          cur_id_d = benchmark;
          len_d    = LenOne;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  // A full buffer that is being accepted this cycle can take a new entry.
  always_comb begin
    accept    = valid_q & ready;
    valid_d   = valid_q & ~accept;
    buf_id_d  = buf_id_q;
    buf_len_d = buf_len_q;
    ovf_d     = ovf_q;
    if (emit) begin
      if (!valid_q || accept) begin
        valid_d   = 1'b1;
        buf_id_d  = cur_id_q;
        buf_len_d = len_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign active = (state_q == B_RUN);
  assign valid  = valid_q;
  assign id     = buf_id_q;
  assign cycles = buf_len_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/ctrl_exit_monitor.sv
// End-of-test monitor: sticky exit/timeout status plus benchmark region timing.
module ctrl_exit_monitor
  import ctrl_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int CntWidth      = 64,
  parameter int TimeoutCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] exit_i,
  input  logic [DataWidth-1:0] benchmark_i,
  input  logic                 clear_i,
  output logic                 done_o,
  output logic                 ok_o,
  output logic                 timeout_o,
  output logic [DataWidth-2:0] exit_code_o,
  output logic                 bench_active_o,
  output logic                 bench_valid_o,
  input  logic                 bench_ready_i,
  output logic [DataWidth-1:0] bench_id_o,
  output logic [CntWidth-1:0]  bench_cycles_o,
  output logic                 bench_ovf_o
);

  localparam bit                  WdEnable = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] WdLimit  =
    (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;
  localparam logic [CntWidth-1:0] CntMax   = '1;

  top_state_e           state_q, state_d;
  logic [CntWidth-1:0]  gcnt_q, gcnt_d;
  logic                 ok_q, ok_d;
  logic                 timeout_q, timeout_d;
  logic [DataWidth-2:0] code_q, code_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      gcnt_q    <= '0;
      ok_q      <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
    end else if (clear_i) begin
      state_q   <= RUN;
      gcnt_q    <= '0;
      ok_q      <= 1'b0;
      timeout_q <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      ok_q      <= ok_d;
      timeout_q <= timeout_d;
      code_q    <= code_d;
    end
  end

  // Exit beats the watchdog when both land in the same cycle.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    ok_d      = ok_q;
    timeout_d = timeout_q;
    code_d    = code_q;
    case (state_q)
      RUN: begin
        if (gcnt_q != CntMax) begin
          gcnt_d = gcnt_q + CntWidth'(1);
        end
        if (exit_i[0]) begin
          code_d  = exit_i[DataWidth-1:1];
          ok_d    = (exit_i[DataWidth-1:1] == '0);
          state_d = DONE;
        end else if (WdEnable && (gcnt_q == WdLimit)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = RUN;
    endcase
  end

  assign done_o      = (state_q == DONE);
  assign ok_o        = ok_q;
  assign timeout_o   = timeout_q;
  assign exit_code_o = code_q;

  ctrl_bench_timer #(
    .DataWidth(DataWidth),
    .CntWidth (CntWidth)
  ) u_bench_timer (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (clear_i),
    .benchmark(benchmark_i),
    .ready    (bench_ready_i),
    .active   (bench_active_o),
    .valid    (bench_valid_o),
    .id       (bench_id_o),
    .cycles   (bench_cycles_o),
    .ovf      (bench_ovf_o)
  );

endmodule

// File: tb/tb_ctrl_exit_monitor.sv
// Self-checking bench: directed scenarios plus random traffic against a
// region/event-level reference model of the exit monitor.
module tb_ctrl_exit_monitor;

  localparam int Timeout = 100;

  logic        clk;
  logic        rst;
  logic [31:0] exitIn;
  logic [31:0] benchIn;
  logic        clearIn;
  logic        readyIn;
  logic        done;
  logic        ok;
  logic        timeout;
  logic [30:0] exitCode;
  logic        benchActive;
  logic        benchValid;
  logic [31:0] benchId;
  logic [63:0] benchCycles;
  logic        benchOvf;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  bit          mDone, mOk, mTimeout;
  logic [30:0] mCode;
  longint      mElapsed;
  bit          mInRegion;
  logic [31:0] mId;
  logic [63:0] mLen;
  bit          mValid, mOvf;
  logic [31:0] mBufId;
  logic [63:0] mBufLen;

  ctrl_exit_monitor #(
    .DataWidth    (32),
    .CntWidth     (64),
    .TimeoutCycles(Timeout)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .exit_i        (exitIn),
    .benchmark_i   (benchIn),
    .clear_i       (clearIn),
    .done_o        (done),
    .ok_o          (ok),
    .timeout_o     (timeout),
    .exit_code_o   (exitCode),
    .bench_active_o(benchActive),
    .bench_valid_o (benchValid),
    .bench_ready_i (readyIn),
    .bench_id_o    (benchId),
    .bench_cycles_o(benchCycles),
    .bench_ovf_o   (benchOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mDone = 0; mOk = 0; mTimeout = 0; mCode = '0; mElapsed = 0;
    mInRegion = 0; mId = '0; mLen = '0;
    mValid = 0; mOvf = 0; mBufId = '0; mBufLen = '0;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic modelStep();
    bit          accepted, haveEmit;
    logic [31:0] eId;
    logic [63:0] eLen;
    if (clearIn) begin
      modelReset();
      return;
    end
    if (!mDone) begin
      if (exitIn[0]) begin
        mDone = 1; mCode = exitIn[31:1]; mOk = (exitIn[31:1] == 31'd0);
      end else if (mElapsed == Timeout - 1) begin
        mDone = 1; mTimeout = 1;
      end
      mElapsed++;
    end
    accepted = mValid && readyIn;
    haveEmit = mInRegion && (benchIn != mId);
    eId = mId;
    eLen = mLen;
    if (benchIn == 0) begin
      mInRegion = 0;
    end else if (mInRegion && benchIn == mId) begin
      mLen = mLen + 1;
    end else begin
      mInRegion = 1; mId = benchIn; mLen = 1;
    end
    if (accepted) mValid = 0;
    if (haveEmit) begin
      if (!mValid) begin
        mValid = 1; mBufId = eId; mBufLen = eLen;
      end else begin
        mOvf = 1;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("done", done, mDone);
    checkVal("ok", ok, mOk);
    checkVal("timeout", timeout, mTimeout);
    checkVal("exit_code", exitCode, mCode);
    checkVal("bench_active", benchActive, mInRegion);
    checkVal("bench_valid", benchValid, mValid);
    checkVal("bench_ovf", benchOvf, mOvf);
    if (mValid) begin
      checkVal("bench_id", benchId, mBufId);
      checkVal("bench_cycles", benchCycles, mBufLen);
    end
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_done"}, done, 0);
    checkVal({tag, "_ok"}, ok, 0);
    checkVal({tag, "_timeout"}, timeout, 0);
    checkVal({tag, "_code"}, exitCode, 0);
    checkVal({tag, "_active"}, benchActive, 0);
    checkVal({tag, "_valid"}, benchValid, 0);
    checkVal({tag, "_id"}, benchId, 0);
    checkVal({tag, "_cycles"}, benchCycles, 0);
    checkVal({tag, "_ovf"}, benchOvf, 0);
  endtask

  // Called at a negedge: drive one cycle of inputs, clock, compare.
  task automatic applyStimulus(input logic [31:0] e, input logic [31:0] b,
                               input logic r, input logic c);
    exitIn = e; benchIn = b; readyIn = r; clearIn = c;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic applyReset();
    #2;
    rst = 1'b1;
    exitIn = '0; benchIn = '0; readyIn = 1'b0; clearIn = 1'b0;
    #1;
    checkZero("async_rst");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    logic [31:0] e, b;
    rst = 1'b1;
    exitIn = '0; benchIn = '0; readyIn = 1'b0; clearIn = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkZero("reset");

    applyStimulus(32'h1, 0, 0, 0);
    checkVal("pass_done", done, 1);
    checkVal("pass_ok", ok, 1);
    checkVal("pass_code", exitCode, 0);
    applyStimulus(32'h7, 0, 0, 0);
    checkVal("sticky_ok", ok, 1);
    checkVal("sticky_code", exitCode, 0);

    applyStimulus(0, 0, 0, 1);
    applyStimulus(32'h7, 0, 0, 0);
    checkVal("fail_done", done, 1);
    checkVal("fail_ok", ok, 0);
    checkVal("fail_code", exitCode, 3);

    applyStimulus(0, 0, 0, 1);
    repeat (Timeout - 1) applyStimulus(0, 0, 0, 0);
    checkVal("wd_early", timeout, 0);
    applyStimulus(0, 0, 0, 0);
    checkVal("wd_timeout", timeout, 1);
    checkVal("wd_done", done, 1);

    applyStimulus(0, 0, 0, 1);
    repeat (Timeout - 1) applyStimulus(0, 0, 0, 0);
    applyStimulus(32'h1, 0, 0, 0);
    checkVal("race_ok", ok, 1);
    checkVal("race_timeout", timeout, 0);
    checkVal("race_done", done, 1);

    repeat (10) applyStimulus(0, 5, 1, 0);
    checkVal("b5_active", benchActive, 1);
    applyStimulus(0, 0, 1, 0);
    checkVal("b5_valid", benchValid, 1);
    checkVal("b5_id", benchId, 5);
    checkVal("b5_cycles", benchCycles, 10);
    applyStimulus(0, 0, 1, 0);
    checkVal("b5_accepted", benchValid, 0);

    repeat (3) applyStimulus(0, 5, 1, 0);
    applyStimulus(0, 9, 1, 0);
    checkVal("b2b_first_id", benchId, 5);
    checkVal("b2b_first_cycles", benchCycles, 3);
    repeat (2) applyStimulus(0, 9, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkVal("b2b_second_id", benchId, 9);
    checkVal("b2b_second_cycles", benchCycles, 3);
    applyStimulus(0, 0, 1, 0);

    repeat (2) applyStimulus(0, 3, 0, 0);
    applyStimulus(0, 0, 0, 0);
    repeat (2) applyStimulus(0, 4, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkVal("bp_valid", benchValid, 1);
    checkVal("bp_id", benchId, 3);
    checkVal("bp_cycles", benchCycles, 2);
    checkVal("bp_ovf", benchOvf, 1);

    applyStimulus(0, 0, 0, 1);
    checkZero("clear");

    repeat (3) applyStimulus(0, 6, 1, 0);
    applyReset();
    repeat (4) applyStimulus(0, 6, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkVal("post_rst_id", benchId, 6);
    checkVal("post_rst_cycles", benchCycles, 4);

    b = '0;
    for (int i = 0; i < 3000; i++) begin
      e = 32'($urandom_range(0, 3)) << 1;
      if ($urandom_range(0, 59) == 0) e = e | 32'h1;
      if ($urandom_range(0, 3) == 0) begin
        b = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(1, 4));
      end
      applyStimulus(e, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 249) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
